// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector: valid/ready word intake, registered 1-bit x output.
// Optional trailing even-parity bit per word when SERIALIZER_PARITY_EN is defined.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for a word, x held at IDLE_LEVEL, in_ready high
// S_SHIFT | driving data (and parity) bits, x_valid high
// S_GAP   | inter-word idle cycles, x at IDLE_LEVEL, in_ready low
module bit_serializer #(
   parameter int   WIDTH      = 8,
   parameter int   MSB_FIRST  = 1,
   parameter int   GAP        = 0,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             word_done
);

   localparam int CW = $clog2(WIDTH + 1);
`ifdef SERIALIZER_PARITY_EN
   localparam bit PAR_EN = 1'b1;
   localparam int LAST   = WIDTH;
`else
   localparam bit PAR_EN = 1'b0;
   localparam int LAST   = WIDTH - 1;
`endif
   localparam logic [CW-1:0] LAST_C    = CW'(LAST);
   localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
   localparam logic [3:0]    GAP_LOAD  = 4'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [3:0]       gap_q, gap_d;
   logic             x_q, x_d;
   logic             par_q, par_d;
   logic             rdy_en_q;
   logic             last_bit;
   logic             accept;
   logic             head_bit;
   logic             load_bit;

   // The next bit to send always sits at the leading end of sreg_q.
   function automatic logic [WIDTH-1:0] shift_w(input logic [WIDTH-1:0] v);
      return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
   endfunction

   assign head_bit = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];
   assign load_bit = (MSB_FIRST != 0) ? in_data[WIDTH-1] : in_data[0];

   assign last_bit  = (state_q == S_SHIFT) && (cnt_q == LAST_C);
   assign in_ready  = rdy_en_q && ((state_q == S_IDLE) || ((GAP == 0) && last_bit));
   assign accept    = in_valid && in_ready;
   assign x         = x_q;
   assign x_valid   = (state_q == S_SHIFT);
   assign busy      = (state_q != S_IDLE);
   assign word_done = last_bit;

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      par_d   = par_q;
      x_d     = IDLE_LEVEL;
      if (accept) begin
         state_d = S_SHIFT;
         sreg_d  = shift_w(in_data);
         cnt_d   = '0;
         par_d   = ^in_data;
         x_d     = load_bit;
      end else begin
         case (state_q)
            S_SHIFT: begin
               if (last_bit) begin
                  if (GAP > 0) begin
                     state_d = S_GAP;
                     gap_d   = GAP_LOAD;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
                  if (PAR_EN && (cnt_q == LAST_DATA)) begin
                     x_d = par_q;
                  end else begin
                     x_d    = head_bit;
                     sreg_d = shift_w(sreg_q);
                  end
               end
            end
            S_GAP: begin
               if (gap_q == 4'd0) state_d = S_IDLE;
               else               gap_d   = gap_q - 4'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         sreg_q   <= '0;
         cnt_q    <= '0;
         gap_q    <= '0;
         x_q      <= IDLE_LEVEL;
         par_q    <= 1'b0;
         rdy_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sreg_q   <= sreg_d;
         cnt_q    <= cnt_d;
         gap_q    <= gap_d;
         x_q      <= x_d;
         par_q    <= par_d;
         rdy_en_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: lane A (MSB first, no gap, idle 0), lane B (LSB first, gap 3, idle 1).
// Expected bits are queued at each accept and popped on every x_valid cycle.
module tb_bit_serializer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] da, db;
   logic       va, vb;
   logic       ra, xa, xva, ba, wda;
   logic       rb, xb, xvb, bb, wdb;

`ifdef SERIALIZER_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   typedef struct {
      logic b;
      logic last;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t ea, eb;
   int   n_vec = 0;
   int   n_err = 0;
   int   run_a = 0;
   int   max_run_a = 0;
   int   gap_b = 0;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(0), .IDLE_LEVEL(1'b0)) u_a (
      .clk(clk), .reset(reset), .in_data(da), .in_valid(va), .in_ready(ra),
      .x(xa), .x_valid(xva), .busy(ba), .word_done(wda));

   bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP(3), .IDLE_LEVEL(1'b1)) u_b (
      .clk(clk), .reset(reset), .in_data(db), .in_valid(vb), .in_ready(rb),
      .x(xb), .x_valid(xvb), .busy(bb), .word_done(wdb));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic push_word(input bit sel, input logic [7:0] w);
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         e.b    = sel ? w[i] : w[7-i];
         e.last = (i == 7) && !PAR;
         if (sel) q_b.push_back(e);
         else     q_a.push_back(e);
      end
      if (PAR) begin
         e.b    = ^w;
         e.last = 1'b1;
         if (sel) q_b.push_back(e);
         else     q_a.push_back(e);
      end
   endtask

   // Called just after a negedge; returns at the negedge following the accept edge, valid left high.
   task automatic send(input bit sel, input logic [7:0] w);
      int n = 0;
      if (sel) begin db = w; vb = 1'b1; end
      else     begin da = w; va = 1'b1; end
      while (!(sel ? rb : ra) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!(sel ? rb : ra)) check(sel ? "b_rdy_tmo" : "a_rdy_tmo", sel ? rb : ra, 1);
      else push_word(sel, w);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (xva) begin
            if (q_a.size() == 0) check("a_extra_bit", xva, 0);
            else begin
               ea = q_a.pop_front();
               check("a_x", xa, ea.b);
               check("a_done", wda, ea.last);
            end
            check("a_rdy_last", ra, wda);
            run_a++;
            if (run_a > max_run_a) max_run_a = run_a;
         end else begin
            check("a_idle_x", xa, 0);
            check("a_idle_done", wda, 0);
            run_a = 0;
         end

         if (xvb) begin
            if (q_b.size() == 0) check("b_extra_bit", xvb, 0);
            else begin
               eb = q_b.pop_front();
               check("b_x", xb, eb.b);
               check("b_done", wdb, eb.last);
            end
            check("b_rdy_shift", rb, 0);
         end else begin
            check("b_idle_x", xb, 1);
            check("b_idle_done", wdb, 0);
         end

         if (gap_b > 0) begin
            if (gap_b <= 3) begin
               check("b_gap_rdy", rb, 0);
               check("b_gap_busy", bb, 1);
               check("b_gap_xv", xvb, 0);
               gap_b++;
            end else begin
               check("b_gap_end_rdy", rb, 1);
               gap_b = 0;
            end
         end
         if (wdb) gap_b = 1;
      end
   end

   initial begin
      int n;
      reset = 1'b1;
      va = 1'b0; vb = 1'b0; da = 8'h00; db = 8'h00;
      #1 reset = 1'b0;
      #1;
      check("rst_xa", xa, 0);
      check("rst_xva", xva, 0);
      check("rst_busy", ba, 0);
      check("rst_done", wda, 0);
      check("rst_rdy_a", ra, 0);
      check("rst_xb", xb, 1);
      check("rst_rdy_b", rb, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1 check("rdy_before_clk", ra, 0);
      @(negedge clk);
      check("rdy_after_rel_a", ra, 1);
      check("rdy_after_rel_b", rb, 1);
      mon_en = 1'b1;

      send(0, 8'hA5);
      va = 1'b0;
      repeat (12) @(negedge clk);

      send(0, 8'h3C);
      da = 8'hFF;
      va = 1'b0;
      repeat (12) @(negedge clk);

      max_run_a = 0;
      send(0, 8'hF0);
      send(0, 8'h0F);
      va = 1'b0;
      repeat (12) @(negedge clk);
      check("b2b_run", max_run_a, PAR ? 18 : 16);

      send(1, 8'h01);
      vb = 1'b0;
      repeat (14) @(negedge clk);

      send(1, 8'h81);
      send(1, 8'h81);
      vb = 1'b0;
      n = 0;
      while (!wdb && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!wdb) check("b_done_tmo", wdb, 1);
      @(negedge clk);
      db = 8'hAA;
      vb = 1'b1;
      @(negedge clk);
      vb = 1'b0;
      repeat (14) @(negedge clk);

      send(0, 8'hFF);
      repeat (3) @(negedge clk);
      #1 reset = 1'b0;
      q_a.delete();
      q_b.delete();
      #1;
      check("rst_mid_xv", xva, 0);
      check("rst_mid_x", xa, 0);
      check("rst_mid_done", wda, 0);
      check("rst_mid_busy", ba, 0);
      check("rst_mid_rdy", ra, 0);
      va = 1'b0;
      @(negedge clk);
      #1 reset = 1'b1;
      #1 check("rst_rel_rdy0", ra, 0);
      @(negedge clk);
      check("rst_rel_rdy1", ra, 1);
      repeat (3) @(negedge clk);

      send(0, 8'h07);
      va = 1'b0;
      repeat (12) @(negedge clk);

      check("a_queue_drained", q_a.size(), 0);
      check("b_queue_drained", q_b.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got %0t want finish", $time);
      $fatal(1);
   end

endmodule
